// File: rtl/sipo_if.sv
// Word-side and bit-side signals of the serial-in parallel-out deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface sipo_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH);

   logic             serial_in;
   logic             serial_valid;
   logic             frame_start;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    bit_count;
   logic             overflow;
   logic             clear_overflow;

   modport slave (
      input  serial_in, serial_valid, frame_start, out_ready, clear_overflow,
      output parallel_out, out_valid, bit_count, overflow
   );

   modport master (
      output serial_in, serial_valid, frame_start, out_ready, clear_overflow,
      input  parallel_out, out_valid, bit_count, overflow
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver with bit strobe, frame realignment, a one-word
// holding register on a valid/ready port, and a sticky overflow flag.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic   clk,
   input  logic   reset_n,
   sipo_if.slave  bus,
   output logic   hold_full_dbg
);
   localparam int CW = $clog2(WIDTH);

   // Handshake: a word transfers on every rising edge where out_valid && out_ready.
   // out_valid is a pure register output; out_ready only steers the next state.
   typedef enum logic {S_EMPTY, S_FULL} hold_state_t;

   hold_state_t      state, state_next;
   logic [WIDTH-1:0] sr, sr_next, base, shifted, word_q;
   logic [CW-1:0]    cnt, cnt_next;
   logic             accept, complete, load, set_ovf, ovf;

   // A realign starts the new word from an empty register.
   assign base     = bus.frame_start ? '0 : sr;
   assign shifted  = MSB_FIRST ? {base[WIDTH-2:0], bus.serial_in}
                               : {bus.serial_in, base[WIDTH-1:1]};
   assign accept   = bus.serial_valid && !bus.frame_start;
   assign complete = accept && (cnt == CW'(WIDTH - 1));

   always_comb begin
      sr_next  = sr;
      cnt_next = cnt;
      if (bus.frame_start) begin
         sr_next  = bus.serial_valid ? shifted : '0;
         cnt_next = bus.serial_valid ? CW'(1) : '0;
      end else if (bus.serial_valid) begin
         sr_next  = shifted;
         cnt_next = complete ? '0 : cnt + CW'(1);
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      set_ovf    = 1'b0;
      case (state)
         S_EMPTY: begin
            if (complete) begin
               load       = 1'b1;
               state_next = S_FULL;
            end
         end
         S_FULL: begin
            if (complete && bus.out_ready) begin
               load = 1'b1;
            end else if (complete) begin
               set_ovf = 1'b1;
            end else if (bus.out_ready) begin
               state_next = S_EMPTY;
            end
         end
         default: state_next = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_EMPTY;
      else          state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sr     <= '0;
         cnt    <= '0;
         word_q <= '0;
         ovf    <= 1'b0;
      end else begin
         sr  <= sr_next;
         cnt <= cnt_next;
         if (load) word_q <= shifted;
         // A drop in the same cycle as a clear keeps the flag set.
         if (set_ovf)                 ovf <= 1'b1;
         else if (bus.clear_overflow) ovf <= 1'b0;
      end
   end

   assign bus.parallel_out = word_q;
   assign bus.out_valid    = (state == S_FULL);
   assign bus.bit_count    = cnt;
   assign bus.overflow     = ovf;
   assign hold_full_dbg    = (state == S_FULL);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Drives one bit stream into an MSB-first and an LSB-first deserializer and
// checks both every cycle against a queue-based model of the receiver.
module tb_sipo_deserializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic serial_in = 1'b0, serial_valid = 1'b0, frame_start = 1'b0;
  logic out_ready = 1'b0, clear_overflow = 1'b0;
  logic dbg_m, dbg_l;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sipo_if #(.WIDTH(W)) bus_m ();
  sipo_if #(.WIDTH(W)) bus_l ();

  assign bus_m.serial_in = serial_in;       assign bus_l.serial_in = serial_in;
  assign bus_m.serial_valid = serial_valid; assign bus_l.serial_valid = serial_valid;
  assign bus_m.frame_start = frame_start;   assign bus_l.frame_start = frame_start;
  assign bus_m.out_ready = out_ready;       assign bus_l.out_ready = out_ready;
  assign bus_m.clear_overflow = clear_overflow;
  assign bus_l.clear_overflow = clear_overflow;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .bus(bus_m.slave), .hold_full_dbg(dbg_m));
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .bus(bus_l.slave), .hold_full_dbg(dbg_l));

  // ---------------- reference model ----------------
  bit          bits[$];
  bit          m_valid = 0, m_ovf = 0, m_armed = 0;
  logic [W-1:0] m_word_m = '0, m_word_l = '0;

  always @(posedge clk) begin
    logic [W-1:0] wm, wl;
    bit done, drop;
    if (!reset_n) begin
      bits.delete();
      m_valid = 0; m_ovf = 0; m_word_m = '0; m_word_l = '0;
      m_armed = 1;
    end else begin
      done = 0; drop = 0; wm = '0; wl = '0;
      if (frame_start) begin
        bits.delete();
        if (serial_valid) bits.push_back(serial_in);
      end else if (serial_valid) begin
        bits.push_back(serial_in);
        if (bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          bits.delete();
          done = 1;
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_valid = 1; m_word_m = wm; m_word_l = wl;
        end else drop = 1;
      end else if (m_valid && out_ready) m_valid = 0;
      if (drop) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_armed) begin
      check("m_word",  32'(bus_m.parallel_out), 32'(m_word_m));
      check("l_word",  32'(bus_l.parallel_out), 32'(m_word_l));
      check("m_valid", 32'(bus_m.out_valid), 32'(m_valid));
      check("l_valid", 32'(bus_l.out_valid), 32'(m_valid));
      check("m_cnt",   32'(bus_m.bit_count), 32'(bits.size()));
      check("l_cnt",   32'(bus_l.bit_count), 32'(bits.size()));
      check("m_ovf",   32'(bus_m.overflow), 32'(m_ovf));
      check("l_ovf",   32'(bus_l.overflow), 32'(m_ovf));
      check("m_dbg",   32'(dbg_m), 32'(m_valid));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic sv, input logic si, input logic fs);
    serial_valid = sv; serial_in = si; frame_start = fs;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_word_msb(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] rnd;
    pat = 8'hC1;

    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_word", 32'(bus_m.parallel_out), 32'h0);
    check("rst_valid", 32'(bus_m.out_valid), 32'h0);
    reset_n = 1'b1;

    // Basic word, consumer always ready
    out_ready = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(pat[i]);
      if (i == 3) check("mid_cnt", 32'(bus_m.bit_count), 32'd5);
    end
    check("basic_msb", 32'(bus_m.parallel_out), 32'hC1);
    check("basic_lsb", 32'(bus_l.parallel_out), 32'h83);
    check("basic_valid", 32'(bus_m.out_valid), 32'h1);
    idle();
    check("basic_drain", 32'(bus_m.out_valid), 32'h0);

    // Same word with 3-cycle gaps; bit_count must hold through them
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(pat[i]);
      for (int g = 0; g < 3; g++) begin
        idle();
        check("gap_cnt", 32'(bus_l.bit_count), 32'((W - i) % W));
      end
    end
    check("gap_lsb", 32'(bus_l.parallel_out), 32'h83);

    // Back-pressure: second word dropped, first held, overflow raised
    out_ready = 1'b0;
    send_word_msb(8'h3C);
    send_word_msb(8'hF0);
    check("bp_word", 32'(bus_m.parallel_out), 32'h3C);
    check("bp_ovf", 32'(bus_m.overflow), 32'h1);
    check("bp_valid", 32'(bus_m.out_valid), 32'h1);
    out_ready = 1'b1;
    idle();
    check("bp_drain", 32'(bus_m.out_valid), 32'h0);
    out_ready = 1'b0;
    clear_overflow = 1'b1;
    idle();
    clear_overflow = 1'b0;
    check("ovf_clear", 32'(bus_m.overflow), 32'h0);

    // Back-to-back: ready rises on the cycle the next word completes
    send_word_msb(8'h3C);
    pat = 8'hF0;
    for (int i = W - 1; i >= 1; i--) send_bit(pat[i]);
    check("b2b_hold", 32'(bus_m.parallel_out), 32'h3C);
    out_ready = 1'b1;
    send_bit(pat[0]);
    check("b2b_word", 32'(bus_m.parallel_out), 32'hF0);
    check("b2b_valid", 32'(bus_m.out_valid), 32'h1);
    check("b2b_ovf", 32'(bus_m.overflow), 32'h0);
    idle();

    // Realign after garbage
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    cyc(1'b1, 1'b1, 1'b1);
    check("realign_cnt", 32'(bus_m.bit_count), 32'h1);
    pat = 8'hC1;
    for (int i = W - 2; i >= 0; i--) send_bit(pat[i]);
    check("realign_word", 32'(bus_m.parallel_out), 32'hC1);
    idle();

    // Reset mid-operation with a held word and a partial word
    out_ready = 1'b0;
    send_word_msb(8'hA5);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    check("mrst_word", 32'(bus_m.parallel_out), 32'h0);
    check("mrst_valid", 32'(bus_m.out_valid), 32'h0);
    check("mrst_cnt", 32'(bus_m.bit_count), 32'h0);
    out_ready = 1'b1;
    rnd = W'($urandom);
    send_word_msb(rnd);
    check("post_rst_word", 32'(bus_m.parallel_out), 32'(rnd));
    idle();

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset_n        = ($urandom_range(0, 299) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 24) == 0);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 39) == 0));
    end
    reset_n = 1'b1;
    clear_overflow = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-in parallel-out deserializer: collects `WIDTH` serial bits, selectable MSB-first or LSB-first, into a word. It presents the word on a valid/ready output port backed by a one-word holding register. Bit strobe, frame realignment and overflow flagging make it usable as the receive half of serial links in the sequential library. The bare shift register can neither tolerate gaps in the bit stream nor back-pressure its consumer; this block does both.

## Interface
- `WIDTH`, 8: word length in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = first received bit lands in `parallel_out[WIDTH-1]` (left shift, new bit into LSB); 0 = first received bit lands in `parallel_out[0]` (right shift, new bit into MSB).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on rising `clk`.
- `serial_in` input 1: serial data bit, sampled only when `serial_valid`=1.
- `serial_valid` input 1: bit strobe; one bit accepted per cycle where high.
- `frame_start` input 1: realign; the current partial word is discarded.
- `parallel_out` output WIDTH: holding-register word.
- `out_valid` output 1: holding register full.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `bit_count` output $clog2(WIDTH): bits collected in the current partial word, 0..WIDTH-1.
- `overflow` output 1: sticky; a completed word was dropped.
- `clear_overflow` input 1: clears `overflow`.

## Operation
- Internal shift register `sr[WIDTH-1:0]` and counter `cnt` (drives `bit_count`).
- Accept cycle (`serial_valid`=1, `frame_start`=0): shift `serial_in` into `sr` per `MSB_FIRST`; `cnt` increments.
- Completion: accept cycle with `cnt`=WIDTH-1. The completed word (`sr` with this bit included) is formed and `cnt` wraps to 0. `sr` is don't-care afterwards because the next word fully overwrites it.
- Output holding register, two states:
  - EMPTY (`out_valid`=0): on completion, load the word and go to FULL.
  - FULL (`out_valid`=1): `out_ready`=1 with no completion goes to EMPTY. `out_ready`=1 with a completion in the same cycle loads the new word and stays FULL. `out_ready`=0 with a completion drops the new word, sets `overflow`, and keeps the old word.
- `frame_start`=1 with `serial_valid`=1: discard the partial word, shift `serial_in` in as bit 0 of a new word, `cnt`=1. Completion cannot occur that cycle.
- `frame_start`=1 with `serial_valid`=0: `cnt`=0, `sr` cleared.
- `frame_start` never affects the holding register, `out_valid` or `overflow`.
- `overflow`: set wins over `clear_overflow` in the same cycle; otherwise `clear_overflow`=1 clears it.
- `serial_in` is ignored when `serial_valid`=0; gaps of any length preserve `sr` and `cnt`.

## Timing
- Reset (`reset_n`=0 at an edge): `sr`=0, `cnt`=0 (`bit_count`=0), `parallel_out`=0, `out_valid`=0, `overflow`=0. This is mid-operation safe: a partial word and a held word are both discarded.
- Latency: the word appears on `parallel_out` with `out_valid`=1 on the cycle after the edge that accepts its WIDTH-th bit. Minimum word period is WIDTH cycles.
- `parallel_out` is stable while `out_valid`=1 and `out_ready`=0.
- `parallel_out` keeps its last value after drain (`out_valid`=0); the consumer ignores it.
- `out_ready` is ignored while `out_valid`=0.
- Handshake is registered only; there is no combinational path from `out_ready` or `serial_*` to any output.
- `bit_count` reflects post-edge `cnt`.

## Test plan
- WIDTH=8, MSB_FIRST=1, `out_ready`=1: bits 1,1,0,0,0,0,0,1 on 8 consecutive cycles → `parallel_out`=8'hC1, `out_valid`=1 for exactly 1 cycle, starting the cycle after the 8th bit.
- Same bits with MSB_FIRST=0 → 8'h83. Then insert 3-cycle `serial_valid` gaps between every bit → still 8'h83, and `bit_count` holds during the gaps.
- `out_ready`=0, send 8'h3C then 8'hF0 → `parallel_out` stays 8'h3C and `overflow`=1 after the 16th bit. Then `out_ready`=1 for 1 cycle → `out_valid`=0. Then `clear_overflow` → `overflow`=0.
- Back-to-back: `out_valid`=1 with `out_ready`=1 on the cycle the next word completes → `parallel_out` changes 8'h3C→8'hF0, `out_valid` stays 1, `overflow` stays 0.
- After 3 bits of garbage, `frame_start`+`serial_valid` with bit 1, then bits 1,0,0,0,0,0,1 → 8'hC1 (MSB_FIRST=1) and `bit_count`=1 after the realign cycle.
- `reset_n`=0 for 1 cycle after 5 bits with a word held → all outputs 0. A following full 8-bit word is received correctly.
